// File: rtl/fwd_pkg.sv
// Shared definitions for the operand forwarding unit.
//   fwd_state_e : interlock FSM states
//   FWD_SEL_RF  : operand tag meaning "taken from the register file"
//   FWD_EXMEM / FWD_MEMWB / FWD_WB : stage indices on the fwd_* buses
package fwd_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fwd_state_e;

    localparam int FWD_SEL_RF = 0;

    localparam int FWD_EXMEM = 0;
    localparam int FWD_MEMWB = 1;
    localparam int FWD_WB    = 2;

endpackage

// File: rtl/fwd_match.sv
// Per-source forwarding comparator (purely combinational).
// Ports:
//   rs_addr_i, rs_data_i : source register index and its register-file data
//   fwd_valid_i, fwd_rd_addr_i, fwd_data_i, fwd_is_load_i : all downstream stages
//   operand_o  : forwarded operand (youngest matching stage, else register file)
//   tag_o      : 0 = register file, k+1 = stage k
//   load_hit_o : the winning stage still holds an unreturned load
module fwd_match #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3,
    parameter int RA_W    = 5,
    parameter int SEL_W   = 2
) (
    input  logic [RA_W-1:0]         rs_addr_i,
    input  logic [XLEN-1:0]         rs_data_i,
    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic [NUM_FWD*RA_W-1:0] fwd_rd_addr_i,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
    input  logic [NUM_FWD-1:0]      fwd_is_load_i,
    output logic [XLEN-1:0]         operand_o,
    output logic [SEL_W-1:0]        tag_o,
    output logic                    load_hit_o
);
    import fwd_pkg::*;

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        operand_o  = rs_data_i;
        tag_o      = SEL_W'(FWD_SEL_RF);
        load_hit_o = 1'b0;
        if (rs_addr_i != '0) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_valid_i[k] && (fwd_rd_addr_i[k*RA_W +: RA_W] == rs_addr_i)) begin
                    operand_o  = fwd_data_i[k*XLEN +: XLEN];
                    tag_o      = SEL_W'(k + 1);
                    load_hit_o = fwd_is_load_i[k];
                end
            end
        end
    end

endmodule

// File: rtl/operand_forward_unit.sv
// Operand forwarding and load-use interlock at the ID/EX boundary.
// Ports:
//   clk, reset (sync, active-low), flush
//   id_valid, id_rs_addr, id_rs_data       : instruction leaving decode
//   fwd_valid, fwd_rd_addr, fwd_data, fwd_is_load : in-flight results, index 0 youngest
//   stall      : hold PC and IF/ID (combinational from id_* / fwd_*)
//   ex_valid, ex_rs_data, ex_fwd_sel       : registered operands and source tags
//
// state | meaning
// RUN   | normal flow; a load-use hazard stalls this cycle
// STALL | extra stall cycles for LOAD_LAT > 1, counted down by cnt
module operand_forward_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 3,
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 1,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [NUM_SRC*RA_W-1:0]  id_rs_addr,
    input  logic [NUM_SRC*XLEN-1:0]  id_rs_data,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [NUM_FWD*RA_W-1:0]  fwd_rd_addr,
    input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
    input  logic [NUM_FWD-1:0]       fwd_is_load,
    output logic                     stall,
    output logic                     ex_valid,
    output logic [NUM_SRC*XLEN-1:0]  ex_rs_data,
    output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel
);
    import fwd_pkg::*;

    localparam int CNT_W = $clog2(LOAD_LAT + 1);
    // First RUN cycle is one stall and the final STALL cycle (cnt == 0) is another.
    localparam logic [CNT_W-1:0] CNT_INIT = (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

    logic [NUM_SRC*XLEN-1:0]  src_operand;
    logic [NUM_SRC*SEL_W-1:0] src_tag;
    logic [NUM_SRC-1:0]       load_hit;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        fwd_match #(
            .XLEN   (XLEN),
            .NUM_FWD(NUM_FWD),
            .RA_W   (RA_W),
            .SEL_W  (SEL_W)
        ) u_match (
            .rs_addr_i    (id_rs_addr[gi*RA_W +: RA_W]),
            .rs_data_i    (id_rs_data[gi*XLEN +: XLEN]),
            .fwd_valid_i  (fwd_valid),
            .fwd_rd_addr_i(fwd_rd_addr),
            .fwd_data_i   (fwd_data),
            .fwd_is_load_i(fwd_is_load),
            .operand_o    (src_operand[gi*XLEN +: XLEN]),
            .tag_o        (src_tag[gi*SEL_W +: SEL_W]),
            .load_hit_o   (load_hit[gi])
        );
    end

    fwd_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ex_valid_q, ex_valid_d;
    logic [NUM_SRC*XLEN-1:0]  ex_rs_data_q, ex_rs_data_d;
    logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_q, ex_fwd_sel_d;
    logic                     hazard;
    logic                     stall_raw;
    logic                     capture;

    assign hazard = id_valid && (|load_hit);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard) begin
                    stall_raw = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            STALL: begin
                stall_raw = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        // Flush outranks both the interlock and capture.
        if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
        end
    end

    assign stall   = reset && !flush && stall_raw;
    assign capture = id_valid && !stall && !flush;

    always_comb begin
        ex_valid_d   = capture;
        ex_rs_data_d = ex_rs_data_q;
        ex_fwd_sel_d = ex_fwd_sel_q;
        if (capture) begin
            ex_rs_data_d = src_operand;
            ex_fwd_sel_d = src_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            ex_valid_q   <= 1'b0;
            ex_rs_data_q <= '0;
            ex_fwd_sel_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ex_valid_q   <= ex_valid_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_fwd_sel_q <= ex_fwd_sel_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_fwd_sel = ex_fwd_sel_q;

endmodule

// File: tb/tb_operand_forward_unit.sv
module tb_operand_forward_unit;
    import fwd_pkg::*;

    localparam int XLEN     = 32;
    localparam int NUM_SRC  = 2;
    localparam int NUM_FWD  = 3;
    localparam int RA_W     = 5;
    localparam int LOAD_LAT = 2;
    localparam int SEL_W    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush, id_valid;
    logic [RA_W-1:0] rs_addr [NUM_SRC];
    logic [XLEN-1:0] rs_data [NUM_SRC];
    logic            fv      [NUM_FWD];
    logic [RA_W-1:0] frd     [NUM_FWD];
    logic [XLEN-1:0] fdat    [NUM_FWD];
    logic            fld     [NUM_FWD];

    logic [NUM_SRC*RA_W-1:0]  id_rs_addr;
    logic [NUM_SRC*XLEN-1:0]  id_rs_data;
    logic [NUM_FWD-1:0]       fwd_valid, fwd_is_load;
    logic [NUM_FWD*RA_W-1:0]  fwd_rd_addr;
    logic [NUM_FWD*XLEN-1:0]  fwd_data;
    logic                     stall, ex_valid;
    logic [NUM_SRC*XLEN-1:0]  ex_rs_data;
    logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel;

    assign id_rs_addr  = {rs_addr[1], rs_addr[0]};
    assign id_rs_data  = {rs_data[1], rs_data[0]};
    assign fwd_valid   = {fv[2], fv[1], fv[0]};
    assign fwd_is_load = {fld[2], fld[1], fld[0]};
    assign fwd_rd_addr = {frd[2], frd[1], frd[0]};
    assign fwd_data    = {fdat[2], fdat[1], fdat[0]};

    operand_forward_unit #(
        .XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .RA_W(RA_W), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rs_data(id_rs_data),
        .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
        .fwd_is_load(fwd_is_load),
        .stall(stall), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_fwd_sel(ex_fwd_sel)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: first stage (youngest first) writing the same nonzero register wins.
    function automatic void model_src(input int i, output logic [XLEN-1:0] op,
                                      output logic [SEL_W-1:0] tag, output bit ld);
        op  = rs_data[i];
        tag = '0;
        ld  = 1'b0;
        if (rs_addr[i] != 0) begin
            for (int k = 0; k < NUM_FWD; k++) begin
                if (fv[k] && frd[k] == rs_addr[i]) begin
                    op  = fdat[k];
                    tag = SEL_W'(k + 1);
                    ld  = fld[k];
                    break;
                end
            end
        end
    endfunction

    function automatic bit model_hazard();
        logic [XLEN-1:0]  op;
        logic [SEL_W-1:0] tg;
        bit               ld;
        bit               any = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            model_src(i, op, tg, ld);
            if (ld) any = 1'b1;
        end
        return id_valid && any;
    endfunction

    // Model state: stall cycles still owed, plus the expected EX register contents.
    int               m_rem = 0;
    bit               m_valid = 1'b0;
    logic [XLEN-1:0]  m_data [NUM_SRC];
    logic [SEL_W-1:0] m_sel  [NUM_SRC];
    bit               started = 1'b0;

    function automatic bit model_stall();
        return reset && !flush && (m_rem > 0 || model_hazard());
    endfunction

    always @(posedge clk) begin
        bit st, hz, cap;
        logic [XLEN-1:0]  op;
        logic [SEL_W-1:0] tg;
        bit               ld;
        hz  = model_hazard();
        st  = model_stall();
        cap = id_valid && !st && !flush;
        if (!reset) begin
            m_rem   = 0;
            m_valid = 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                m_data[i] = '0;
                m_sel[i]  = '0;
            end
        end else if (flush) begin
            m_rem   = 0;
            m_valid = 1'b0;
        end else begin
            m_valid = cap;
            if (cap) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    model_src(i, op, tg, ld);
                    m_data[i] = op;
                    m_sel[i]  = tg;
                end
            end
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (hz)   m_rem = LOAD_LAT - 1;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_stall", {63'd0, stall}, {63'd0, model_stall()});
            chk("m_ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
            chk("m_ex_rs_data", ex_rs_data, {m_data[1], m_data[0]});
            chk("m_ex_fwd_sel", {60'd0, ex_fwd_sel}, {60'd0, m_sel[1], m_sel[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        for (int k = 0; k < NUM_FWD; k++) begin
            fv[k] = 1'b0; frd[k] = '0; fdat[k] = '0; fld[k] = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; id_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs_addr[i] = '0; rs_data[i] = '0;
        end
        clr_fwd();

        // Reset with a load-use hazard present: stall is forced low.
        id_valid = 1'b1; rs_addr[1] = 5'd7; fv[0] = 1'b1; frd[0] = 5'd7; fld[0] = 1'b1;
        #2 chk("rst_stall", {63'd0, stall}, 64'd0);
        tick(); tick();
        chk("rst_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_data", ex_rs_data, 64'd0);
        chk("rst_sel", {60'd0, ex_fwd_sel}, 64'd0);

        // No hazard, no match.
        reset = 1'b1; clr_fwd();
        rs_addr[0] = 5'd5; rs_data[0] = 32'h11;
        rs_addr[1] = 5'd6; rs_data[1] = 32'h22;
        tick();
        chk("nh_valid", {63'd0, ex_valid}, 64'd1);
        chk("nh_data", ex_rs_data, 64'h00000022_00000011);
        chk("nh_sel", {60'd0, ex_fwd_sel}, 64'd0);

        // Two stages write x5: stage 0 wins.
        fv[0] = 1'b1; frd[0] = 5'd5; fdat[0] = 32'hA;
        fv[1] = 1'b1; frd[1] = 5'd5; fdat[1] = 32'hB;
        tick();
        chk("dm_rs1", {32'd0, ex_rs_data[31:0]}, 64'hA);
        chk("dm_tag1", {62'd0, ex_fwd_sel[1:0]}, 64'd1);
        chk("dm_rs2", {32'd0, ex_rs_data[63:32]}, 64'h22);
        chk("dm_tag2", {62'd0, ex_fwd_sel[3:2]}, 64'd0);

        // x0 is never forwarded.
        clr_fwd();
        fv[0] = 1'b1; frd[0] = 5'd0; fdat[0] = 32'hDEAD;
        rs_addr[0] = 5'd0; rs_data[0] = 32'h0;
        tick();
        chk("x0_rs1", {32'd0, ex_rs_data[31:0]}, 64'd0);
        chk("x0_tag1", {62'd0, ex_fwd_sel[1:0]}, 64'd0);

        // Load-use on rs2, load advances to stage 1 during the stall.
        clr_fwd();
        rs_addr[0] = 5'd5; rs_data[0] = 32'h11;
        rs_addr[1] = 5'd7; rs_data[1] = 32'h99;
        fv[0] = 1'b1; frd[0] = 5'd7; fld[0] = 1'b1;
        #1 chk("lu_stall0", {63'd0, stall}, 64'd1);
        tick();
        chk("lu_bub0", {63'd0, ex_valid}, 64'd0);
        clr_fwd();
        fv[1] = 1'b1; frd[1] = 5'd7; fdat[1] = 32'h55;
        #1 chk("lu_stall1", {63'd0, stall}, 64'd1);
        tick();
        chk("lu_bub1", {63'd0, ex_valid}, 64'd0);
        #1 chk("lu_free", {63'd0, stall}, 64'd0);
        tick();
        chk("lu_valid", {63'd0, ex_valid}, 64'd1);
        chk("lu_rs2", {32'd0, ex_rs_data[63:32]}, 64'h55);
        chk("lu_tag2", {62'd0, ex_fwd_sel[3:2]}, 64'd2);

        // Flush while in STALL; persisting hazard stalls again afterwards.
        clr_fwd();
        fv[0] = 1'b1; frd[0] = 5'd7; fld[0] = 1'b1;
        tick();
        flush = 1'b1;
        #1 chk("fl_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("fl_valid", {63'd0, ex_valid}, 64'd0);
        flush = 1'b0;
        #1 chk("fl_restall", {63'd0, stall}, 64'd1);
        tick();
        clr_fwd();
        fv[1] = 1'b1; frd[1] = 5'd7; fdat[1] = 32'h66;
        tick();
        tick();
        chk("fl_rs2", {32'd0, ex_rs_data[63:32]}, 64'h66);
        chk("fl_tag2", {62'd0, ex_fwd_sel[3:2]}, 64'd2);

        // Reset while in STALL: no residual stall after release.
        clr_fwd();
        fv[0] = 1'b1; frd[0] = 5'd7; fld[0] = 1'b1;
        tick();
        reset = 1'b0;
        #1 chk("rs_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("rs_valid", {63'd0, ex_valid}, 64'd0);
        chk("rs_data", ex_rs_data, 64'd0);
        chk("rs_sel", {60'd0, ex_fwd_sel}, 64'd0);
        reset = 1'b1; clr_fwd();
        rs_addr[0] = 5'd3; rs_data[0] = 32'h33;
        rs_addr[1] = 5'd4; rs_data[1] = 32'h44;
        #1 chk("rs_nostall", {63'd0, stall}, 64'd0);
        tick();
        chk("rs_cap_valid", {63'd0, ex_valid}, 64'd1);
        chk("rs_cap_data", ex_rs_data, 64'h00000044_00000033);

        // id_valid low with a hazard: no stall, bubble, data held.
        id_valid = 1'b0;
        fv[0] = 1'b1; frd[0] = 5'd4; fld[0] = 1'b1;
        #1 chk("iv0_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("iv0_valid", {63'd0, ex_valid}, 64'd0);
        chk("iv0_hold", ex_rs_data, 64'h00000044_00000033);

        // Flush together with a hazard: flush wins.
        id_valid = 1'b1; flush = 1'b1;
        #1 chk("flh_stall", {63'd0, stall}, 64'd0);
        tick();
        flush = 1'b0;

        // Older load to same register ignored; stage 2 only match gives tag 3.
        clr_fwd();
        fv[0] = 1'b1; frd[0] = 5'd3; fdat[0] = 32'h77;
        fv[1] = 1'b1; frd[1] = 5'd3; fld[1] = 1'b1;
        fv[2] = 1'b1; frd[2] = 5'd4; fdat[2] = 32'h88;
        #1 chk("old_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("old_data", ex_rs_data, 64'h00000088_00000077);
        chk("old_sel", {60'd0, ex_fwd_sel}, 64'hD);

        clr_fwd();
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_forward_unit.md
# operand_forward_unit

Parametrised operand-forwarding and load-use interlock block for the ID/EX boundary of the 32I pipeline. It captures the register-file operands of the instruction leaving decode. Each source operand is replaced by the youngest matching in-flight result from up to NUM_FWD downstream stages. When a needed result is a load that has not returned yet, it stalls decode and inserts bubbles. It generalises the two-source, fixed-stage forwarding register to any source count, any stage count, and any load latency, with explicit stall, flush and valid handling.

## Interface
- XLEN, 32, datapath width
- NUM_SRC, 2, source operands per instruction (2 for R/S/B formats; 3 reserved for future fused ops)
- NUM_FWD, 3, forwarding stages; index 0 = EX/MEM (youngest), 1 = MEM/WB, 2 = WB
- RA_W, 5, register address width
- LOAD_LAT, 1, minimum stall cycles per load-use hazard (>= 1)
- clk  in  1  clock; single clock domain, rising edge
- reset  in  1  synchronous, active-low reset
- flush  in  1  synchronous pipeline flush (taken branch or jump)
- id_valid  in  1  decode holds a valid instruction
- id_rs_addr  in  NUM_SRC*RA_W  source register indices; slice i = source i
- id_rs_data  in  NUM_SRC*XLEN  register-file read data
- fwd_valid  in  NUM_FWD  stage k writes a register
- fwd_rd_addr  in  NUM_FWD*RA_W  destination register of stage k
- fwd_data  in  NUM_FWD*XLEN  result of stage k; producer has already muxed ALU, load or pc+4 for JAL/JALR
- fwd_is_load  in  NUM_FWD  stage k holds a load whose data is not yet valid
- stall  out  1  hold the PC and IF/ID registers this cycle
- ex_valid  out  1  EX-side operands are valid
- ex_rs_data  out  NUM_SRC*XLEN  registered, forwarded operands
- ex_fwd_sel  out  NUM_SRC*SEL_W  per-source source tag: 0 = register file, k+1 = stage k; SEL_W = $clog2(NUM_FWD+1)

## Operation
- Match per source i: stage k matches when fwd_valid[k], fwd_rd_addr[k] == id_rs_addr[i], and id_rs_addr[i] != 0.
- Priority: the lowest matching k wins. A younger result always overrides an older one to the same register.
- With no match, the operand is taken from id_rs_data and its tag is 0.
- Register x0 is never forwarded. Its operand is always id_rs_data and its tag is 0.
- Hazard: id_valid is high and some source's winning stage k has fwd_is_load[k] set. Only the winning stage is checked; older loads to the same register are ignored.
- FSM has two states, RUN and STALL, plus a down-counter cnt of width $clog2(LOAD_LAT+1).
- RUN, no hazard: stall = 0.
- RUN, hazard: stall = 1. If LOAD_LAT > 1, go to STALL with cnt = LOAD_LAT-2. Otherwise stay in RUN.
- STALL: stall = 1. Decrement cnt. When cnt == 0, next state is RUN.
- On return to RUN the hazard is re-evaluated. A persisting hazard stalls again.
- stall is forced to 0 while reset is low or flush is high.
- Capture occurs when id_valid && !stall && !flush:
  - ex_valid <= 1
  - ex_rs_data <= forwarded operands
  - ex_fwd_sel <= tags
- In any other cycle: ex_valid <= 0 (bubble), and ex_rs_data and ex_fwd_sel hold their previous values.
- flush (reset high): next cycle state = RUN, cnt = 0, ex_valid = 0. Flush has priority over stall and capture.

## Timing
- Reset values, applied on the clk edge while reset is low: ex_valid 0, ex_rs_data 0, ex_fwd_sel 0, state RUN, cnt 0.
- Reset asserted mid-STALL aborts the stall. There is no residual bubble after reset releases.
- Latency: operands are presented to EX one cycle after decode, at the capture edge.
- Combinational paths: the match and hazard logic is combinational from the fwd_* and id_* inputs to stall. Forwarded data is registered only, with no combinational data path to the outputs.
- Stall length: a load-use hazard produces exactly LOAD_LAT cycles of stall = 1 and ex_valid = 0, provided the load's fwd_is_load clears in time.
- Simultaneous events:
  - flush and hazard together: flush wins, stall = 0.
  - id_valid = 0 and hazard: no stall, bubble.

## Structure
- Shared package fwd_pkg holds:
  - the state enum (RUN, STALL)
  - FWD_SEL_RF = 0
  - stage index constants FWD_EXMEM = 0, FWD_MEMWB = 1, FWD_WB = 2
- Sub-module fwd_match: a combinational per-source priority comparator.
  - Inputs: one address and one data word, plus all fwd_* buses.
  - Outputs: operand, tag and load_hit.
  - Instantiated NUM_SRC times via generate.
- The top level holds the FSM, the counter and the output registers.

## Test plan
- No hazard:
  - Stimulus: rs = {5, 6}, RF data {0x11, 0x22}, no stage matches.
  - Required response: next cycle ex_rs_data = {0x11, 0x22}, tags {0, 0}, ex_valid = 1.
- Double match:
  - Stimulus: stage 0 rd = 5 data 0xA; stage 1 rd = 5 data 0xB; rs1 = 5.
  - Required response: ex rs1 = 0xA, tag 1. rs2 is unaffected.
- x0:
  - Stimulus: stage 0 rd = 0, valid, data 0xDEAD; rs1 = 0, RF data 0.
  - Required response: ex rs1 = 0, tag 0.
- Load-use, LOAD_LAT = 2:
  - Stimulus: stage 0 rd = 7 with fwd_is_load = 1; rs2 = 7. Load then advances to stage 1 with data 0x55 and is_load = 0.
  - Required response: stall = 1 and ex_valid = 0 for 2 cycles. Then ex rs2 = 0x55, tag 2.
- Flush in STALL:
  - Stimulus: flush pulses during cycle 1 of a stall.
  - Required response: next cycle state = RUN and ex_valid = 0. Stall is re-evaluated from the current inputs.
- Reset in STALL:
  - Stimulus: reset goes low during a stall.
  - Required response: all outputs are 0 at the next edge. After release, the first valid non-hazard instruction is captured with a 1-cycle latency.
